// File: rtl/usb_tx_line_ctrl_if.sv
// usb_tx_line_ctrl_if -- byte stream and line-level signals of the USB
// full-speed transmit line controller.
// Optional feature macro: USB_TX_BUS_RESET_EN adds the bus_reset_req request.
interface usb_tx_line_ctrl_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       dp_tx;
    logic       dn_tx;
    logic       tx_oe;
    logic       busy;
    logic       tx_err;
`ifdef USB_TX_BUS_RESET_EN
    logic       bus_reset_req;

    modport master (
        output tx_data, tx_valid, tx_last, bus_reset_req,
        input  tx_ready, dp_tx, dn_tx, tx_oe, busy, tx_err
    );
    modport slave (
        input  tx_data, tx_valid, tx_last, bus_reset_req,
        output tx_ready, dp_tx, dn_tx, tx_oe, busy, tx_err
    );
`else
    modport master (
        output tx_data, tx_valid, tx_last,
        input  tx_ready, dp_tx, dn_tx, tx_oe, busy, tx_err
    );
    modport slave (
        input  tx_data, tx_valid, tx_last,
        output tx_ready, dp_tx, dn_tx, tx_oe, busy, tx_err
    );
`endif
endinterface

// File: rtl/usb_tx_line_ctrl.sv
// usb_tx_line_ctrl -- USB full-speed transmit line controller.
// Serialises a byte stream as SYNC + NRZI/bit-stuffed data + EOP, with a
// one-byte holding register so consecutive bytes go out without a gap.
// Optional feature macro: USB_TX_BUS_RESET_EN compiles in bus_reset_req and
// the BUS_RST state that drives a long SE0 bus reset from IDLE.
module usb_tx_line_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int RESET_BITS = 120
) (
    input  logic              clk,
    input  logic              rst,
    usb_tx_line_ctrl_if.slave bus
);
    localparam int DCW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BCW = ($clog2(RESET_BITS + 1) > 3) ? $clog2(RESET_BITS + 1) : 3;
    localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(7);
    localparam logic [BCW-1:0] SYNC_ONE = BCW'(6);
    localparam logic [1:0]     LINE_J   = 2'b10;
    localparam logic [1:0]     LINE_K   = 2'b01;
    localparam logic [1:0]     LINE_SE0 = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_DATA    = 3'd2,
        ST_EOP_SE0 = 3'd3,
        ST_EOP_J   = 3'd4
`ifdef USB_TX_BUS_RESET_EN
        ,
        ST_BUS_RST = 3'd5
`endif
    } state_t;

    // NRZI: a 0 toggles between J and K, a 1 keeps the previous level
    function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic bit_v);
        return bit_v ? line : {line[0], line[1]};
    endfunction

    state_t           state_r, state_nx;
    logic [DCW-1:0]   div_r, div_nx;
    logic [BCW-1:0]   bit_r, bit_nx;
    logic [6:0]       shift_r, shift_nx;
    logic [7:0]       hold_r, hold_nx;
    logic             hold_full_r, hold_full_nx;
    logic             hold_last_r, hold_last_nx;
    logic             cur_last_r, cur_last_nx;
    logic             last_seen_r, last_seen_nx;
    logic [2:0]       ones_r, ones_nx;
    logic [1:0]       line_r, line_nx;
    logic             oe_r, oe_nx;
    logic             busy_r, busy_nx;
    logic             err_r, err_nx;
    logic             ready_r, ready_nx;

    logic             accept_s;
    logic             strobe_s;
    logic             avail_s;
    logic [7:0]       next_byte_s;
    logic             next_last_s;
    logic             bit_v_s;

`ifdef USB_TX_BUS_RESET_EN
    // a bus reset request in IDLE wins over a byte offered on the same clock
    assign accept_s = bus.tx_valid && ready_r && !((state_r == ST_IDLE) && bus.bus_reset_req);
`else
    assign accept_s = bus.tx_valid && ready_r;
`endif
    assign strobe_s    = (div_r == DIV_LAST);
    // a byte arriving on the reload clock itself is taken straight from the bus
    assign avail_s     = hold_full_r || accept_s;
    assign next_byte_s = hold_full_r ? hold_r : bus.tx_data;
    assign next_last_s = hold_full_r ? hold_last_r : bus.tx_last;

    assign bus.tx_ready = ready_r;
    assign bus.dp_tx    = line_r[1];
    assign bus.dn_tx    = line_r[0];
    assign bus.tx_oe    = oe_r;
    assign bus.busy     = busy_r;
    assign bus.tx_err   = err_r;

    // next-state, serialiser and line-level decisions
    always_comb begin
        state_nx     = state_r;
        div_nx       = div_r;
        bit_nx       = bit_r;
        shift_nx     = shift_r;
        hold_nx      = hold_r;
        hold_full_nx = hold_full_r;
        hold_last_nx = hold_last_r;
        cur_last_nx  = cur_last_r;
        last_seen_nx = last_seen_r;
        ones_nx      = ones_r;
        line_nx      = line_r;
        oe_nx        = oe_r;
        err_nx       = 1'b0;
        ready_nx     = 1'b0;
        bit_v_s      = 1'b0;

        if (accept_s) begin
            hold_nx      = bus.tx_data;
            hold_full_nx = 1'b1;
            hold_last_nx = bus.tx_last;
            last_seen_nx = last_seen_r || bus.tx_last;
        end else begin
            hold_nx = hold_r;
        end

        if (state_r == ST_IDLE) begin
            div_nx = {DCW{1'b0}};
        end else if (strobe_s) begin
            div_nx = {DCW{1'b0}};
        end else begin
            div_nx = div_r + DCW'(1);
        end

        case (state_r)
            ST_IDLE: begin
                bit_nx  = {BCW{1'b0}};
                ones_nx = 3'd0;
                line_nx = LINE_J;
                oe_nx   = 1'b0;
`ifdef USB_TX_BUS_RESET_EN
                if (bus.bus_reset_req) begin
                    state_nx = ST_BUS_RST;
                    line_nx  = LINE_SE0;
                    oe_nx    = 1'b1;
                end else
`endif
                if (accept_s) begin
                    // first SYNC bit is a 0, so the line toggles J -> K at once
                    state_nx = ST_SYNC;
                    line_nx  = LINE_K;
                    oe_nx    = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SYNC, ST_DATA: begin
                if (!strobe_s) begin
                    state_nx = state_r;
                end else if (ones_r == 3'd6) begin
                    // stuffed zero; the data bit pointer does not advance
                    line_nx = {line_r[0], line_r[1]};
                    ones_nx = 3'd0;
                end else if (bit_r != BIT_LAST) begin
                    if (state_r == ST_SYNC) begin
                        bit_v_s = (bit_r == SYNC_ONE);
                    end else begin
                        bit_v_s  = shift_r[0];
                        shift_nx = {1'b0, shift_r[6:1]};
                    end
                    bit_nx  = bit_r + BCW'(1);
                    line_nx = nrzi_next(line_r, bit_v_s);
                    ones_nx = bit_v_s ? (ones_r + 3'd1) : 3'd0;
                end else if ((state_r == ST_DATA) && cur_last_r) begin
                    state_nx = ST_EOP_SE0;
                    line_nx  = LINE_SE0;
                    bit_nx   = {BCW{1'b0}};
                    ones_nx  = 3'd0;
                end else if (avail_s) begin
                    state_nx     = ST_DATA;
                    bit_v_s      = next_byte_s[0];
                    shift_nx     = next_byte_s[7:1];
                    cur_last_nx  = next_last_s;
                    hold_full_nx = 1'b0;
                    bit_nx       = {BCW{1'b0}};
                    line_nx      = nrzi_next(line_r, bit_v_s);
                    ones_nx      = bit_v_s ? (ones_r + 3'd1) : 3'd0;
                end else begin
                    // underrun: abandon the packet with an EOP
                    err_nx   = 1'b1;
                    state_nx = ST_EOP_SE0;
                    line_nx  = LINE_SE0;
                    bit_nx   = {BCW{1'b0}};
                    ones_nx  = 3'd0;
                end
            end
            ST_EOP_SE0: begin
                if (!strobe_s) begin
                    state_nx = ST_EOP_SE0;
                end else if (bit_r == {BCW{1'b0}}) begin
                    bit_nx = BCW'(1);
                end else begin
                    state_nx = ST_EOP_J;
                    line_nx  = LINE_J;
                    bit_nx   = {BCW{1'b0}};
                end
            end
            ST_EOP_J: begin
                if (strobe_s) begin
                    state_nx     = ST_IDLE;
                    line_nx      = LINE_J;
                    oe_nx        = 1'b0;
                    shift_nx     = 7'd0;
                    hold_nx      = 8'd0;
                    hold_full_nx = 1'b0;
                    hold_last_nx = 1'b0;
                    cur_last_nx  = 1'b0;
                    last_seen_nx = 1'b0;
                end else begin
                    state_nx = ST_EOP_J;
                end
            end
`ifdef USB_TX_BUS_RESET_EN
            ST_BUS_RST: begin
                if (!strobe_s) begin
                    state_nx = ST_BUS_RST;
                end else if (bit_r == BCW'(RESET_BITS)) begin
                    state_nx = ST_IDLE;
                    line_nx  = LINE_J;
                    oe_nx    = 1'b0;
                    bit_nx   = {BCW{1'b0}};
                end else if (bit_r == BCW'(RESET_BITS - 1)) begin
                    line_nx = LINE_J;
                    bit_nx  = bit_r + BCW'(1);
                end else begin
                    bit_nx = bit_r + BCW'(1);
                end
            end
`endif
            default: begin
                state_nx = ST_IDLE;
                line_nx  = LINE_J;
                oe_nx    = 1'b0;
            end
        endcase

        busy_nx = (state_r != ST_IDLE);

        if ((state_nx == ST_SYNC) || (state_nx == ST_DATA)) begin
            ready_nx = !hold_full_nx && !last_seen_nx;
        end else if ((state_r == ST_IDLE) && (state_nx == ST_IDLE)) begin
            ready_nx = 1'b1;
        end else begin
            ready_nx = 1'b0;
        end
    end

    // state and output registers; reset releases the line immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            div_r       <= {DCW{1'b0}};
            bit_r       <= {BCW{1'b0}};
            shift_r     <= 7'd0;
            hold_r      <= 8'd0;
            hold_full_r <= 1'b0;
            hold_last_r <= 1'b0;
            cur_last_r  <= 1'b0;
            last_seen_r <= 1'b0;
            ones_r      <= 3'd0;
            line_r      <= LINE_J;
            oe_r        <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            ready_r     <= 1'b0;
        end else begin
            state_r     <= state_nx;
            div_r       <= div_nx;
            bit_r       <= bit_nx;
            shift_r     <= shift_nx;
            hold_r      <= hold_nx;
            hold_full_r <= hold_full_nx;
            hold_last_r <= hold_last_nx;
            cur_last_r  <= cur_last_nx;
            last_seen_r <= last_seen_nx;
            ones_r      <= ones_nx;
            line_r      <= line_nx;
            oe_r        <= oe_nx;
            busy_r      <= busy_nx;
            err_r       <= err_nx;
            ready_r     <= ready_nx;
        end
    end
endmodule

// File: tb/tb_usb_tx_line_ctrl.sv
// tb_usb_tx_line_ctrl -- scoreboard bench for usb_tx_line_ctrl.
// Expected line symbols (J/K/SE0 per bit) and tx_oe lengths are queued when a
// packet is issued; a negedge monitor pops and compares while tx_oe is high.
module tb_usb_tx_line_ctrl;
    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic rst;

    usb_tx_line_ctrl_if bus_if();

    usb_tx_line_ctrl #(.CLK_DIV(CLK_DIV), .RESET_BITS(120)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    logic [1:0] exp_q[$];
    int         len_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         err_pulses = 0;
    int         err_clks = 0;
    bit         mon_en = 1'b0;
    bit         in_pkt = 1'b0;
    bit         busy_chk_pending = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // J = 2'b10, K = 2'b01, '0' = SE0
    task automatic push_pkt(input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (s.getc(i) == "J") exp_q.push_back(2'b10);
            else if (s.getc(i) == "K") exp_q.push_back(2'b01);
            else exp_q.push_back(2'b00);
        end
        len_q.push_back(s.len() * CLK_DIV);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input logic keep_valid);
        logic rdy;
        int   guard;
        bus_if.tx_data  = d;
        bus_if.tx_last  = last;
        bus_if.tx_valid = 1'b1;
        guard = 0;
        do begin
            rdy = bus_if.tx_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && guard < 2000);
        chk("byte_accepted", int'(rdy), 1);
        if (!keep_valid) bus_if.tx_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0 || in_pkt || bus_if.busy ||
                busy_chk_pending) && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk({name, "_done"}, int'(guard < 3000), 1);
    endtask

    // monitor: compares every clock of every bit while the line is driven
    initial begin : monitor
        logic [1:0] cur_sym;
        int         phase;
        int         oe_clks;
        bit         prev_err;
        cur_sym  = 2'b11;
        phase    = 0;
        oe_clks  = 0;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.tx_err && !prev_err) err_pulses++;
            if (bus_if.tx_err) err_clks++;
            prev_err = bus_if.tx_err;
            if (mon_en) begin
                if (bus_if.tx_oe) begin
                    if (!in_pkt) begin
                        in_pkt  = 1'b1;
                        phase   = 0;
                        oe_clks = 0;
                    end
                    if (phase == 0) begin
                        if (exp_q.size() > 0) begin
                            cur_sym = exp_q.pop_front();
                        end else begin
                            chk("line_extra_bit", exp_q.size(), 1);
                            cur_sym = 2'b11;
                        end
                    end
                    chk("line", int'({bus_if.dp_tx, bus_if.dn_tx}), int'(cur_sym));
                    phase = (phase == CLK_DIV - 1) ? 0 : phase + 1;
                    oe_clks++;
                end else if (in_pkt) begin
                    in_pkt = 1'b0;
                    if (len_q.size() > 0) chk("oe_len", oe_clks, len_q.pop_front());
                    else chk("oe_len_extra", len_q.size(), 1);
                    chk("busy_at_oe_fall", int'(bus_if.busy), 1);
                    busy_chk_pending = 1'b1;
                end else if (busy_chk_pending) begin
                    chk("busy_fall", int'(bus_if.busy), 0);
                    busy_chk_pending = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst             = 1'b1;
        bus_if.tx_data  = 8'h00;
        bus_if.tx_valid = 1'b0;
        bus_if.tx_last  = 1'b0;
`ifdef USB_TX_BUS_RESET_EN
        bus_if.bus_reset_req = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dp", int'(bus_if.dp_tx), 1);
        chk("rst_dn", int'(bus_if.dn_tx), 0);
        chk("rst_oe", int'(bus_if.tx_oe), 0);
        chk("rst_busy", int'(bus_if.busy), 0);
        chk("rst_err", int'(bus_if.tx_err), 0);
        chk("rst_ready", int'(bus_if.tx_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_before_first_clk", int'(bus_if.tx_ready), 0);
        @(posedge clk);
        #1;
        chk("ready_after_first_clk", int'(bus_if.tx_ready), 1);
        mon_en = 1'b1;

        // 0xC3 single byte: SYNC, data, SE0 SE0 J
        push_pkt("KJKJKJKKKKJKJKKK00J");
        send_byte(8'hC3, 1'b1, 1'b0);
        wait_done("c3");

        // 0xFF: stuffed toggle after five data ones; then 0xC3 offered during
        // the packet must wait for IDLE and form its own packet
        push_pkt("KJKJKJKKKKKKKJJJJ00J");
        push_pkt("KJKJKJKKKKJKJKKK00J");
        send_byte(8'hFF, 1'b1, 1'b1);
        send_byte(8'hC3, 1'b1, 1'b0);
        wait_done("ff_c3");

        // three back-to-back bytes with tx_valid held
        push_pkt("KJKJKJKKKJJJKKJKJKJKJKJKJKJKKJKJ00J");
        send_byte(8'h2D, 1'b0, 1'b1);
        send_byte(8'h00, 1'b0, 1'b1);
        send_byte(8'h10, 1'b1, 1'b0);
        wait_done("three_bytes");
        chk("no_err_pulses", err_pulses, 0);

        // underrun: second byte never offered
        push_pkt("KJKJKJKKKJJKJJKK00J");
        send_byte(8'hA5, 1'b0, 1'b0);
        wait_done("underrun");
        chk("err_pulses", err_pulses, 1);
        chk("err_clks", err_clks, 1);
        chk("ready_after_underrun", int'(bus_if.tx_ready), 1);

        // reset in the middle of the data phase
        mon_en = 1'b0;
        send_byte(8'hC3, 1'b1, 1'b0);
        repeat (12 * CLK_DIV) @(posedge clk);
        #1;
        chk("oe_before_rst", int'(bus_if.tx_oe), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_dp", int'(bus_if.dp_tx), 1);
        chk("midrst_dn", int'(bus_if.dn_tx), 0);
        chk("midrst_oe", int'(bus_if.tx_oe), 0);
        chk("midrst_busy", int'(bus_if.busy), 0);
        chk("midrst_err", int'(bus_if.tx_err), 0);
        chk("midrst_ready", int'(bus_if.tx_ready), 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("ready_at_release", int'(bus_if.tx_ready), 0);
        @(posedge clk);
        #1;
        chk("ready_after_release", int'(bus_if.tx_ready), 1);
        mon_en = 1'b1;
        push_pkt("KJKJKJKKKKJKJKKK00J");
        send_byte(8'hC3, 1'b1, 1'b0);
        wait_done("after_rst");
        chk("err_after_rst", err_pulses, 1);

`ifdef USB_TX_BUS_RESET_EN
        begin : bus_reset_test
            string s;
            int    cnt;
            s = "";
            for (int i = 0; i < 120; i++) s = {s, "0"};
            s = {s, "J"};
            push_pkt(s);
            push_pkt("KJKJKJKKKKJKJKKK00J");
            bus_if.bus_reset_req = 1'b1;
            bus_if.tx_data       = 8'hC3;
            bus_if.tx_last       = 1'b1;
            bus_if.tx_valid      = 1'b1;
            @(posedge clk);
            #1;
            bus_if.bus_reset_req = 1'b0;
            chk("busrst_ready_low", int'(bus_if.tx_ready), 0);
            cnt = 0;
            while (!bus_if.tx_ready && cnt < 2000) begin
                @(posedge clk);
                #1;
                cnt++;
            end
            chk("busrst_ready_delay", cnt, 485);
            @(posedge clk);
            #1;
            bus_if.tx_valid = 1'b0;
            wait_done("bus_reset");
        end
`endif

        chk("exp_q_empty", exp_q.size(), 0);
        chk("len_q_empty", len_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
